// File: rtl/debug_frame_decoder_pkg.sv
// Shared types and defaults for the debug frame decoder: data width, sync/reply bytes,
// error codes and the one-hot FSM encoding.
package debug_frame_decoder_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SYNC0_DEF = 8'h5A;
  localparam logic [DATA_W-1:0] SYNC1_DEF = 8'hA5;
  localparam logic [DATA_W-1:0] ACK_DEF   = 8'h06;
  localparam logic [DATA_W-1:0] NAK_DEF   = 8'h15;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [7:0] {
    S_HUNT0    = 8'b0000_0001,
    S_HUNT1    = 8'b0000_0010,
    S_CMD      = 8'b0000_0100,
    S_LEN      = 8'b0000_1000,
    S_PAY      = 8'b0001_0000,
    S_CHK      = 8'b0010_0000,
    S_TX_START = 8'b0100_0000,
    S_TX_WAIT  = 8'b1000_0000
  } state_e;

endpackage

// File: rtl/debug_frame_timeout.sv
// Inter-byte watchdog: counts while enabled, restarts on clear, and pulses expire
// combinationally in the cycle the count sits at LIMIT-1 (clear always wins).
module debug_frame_timeout #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_frame_decoder.sv
// Debug UART frame decoder: hunts SYNC0/SYNC1, validates CMD/LEN/payload/checksum,
// streams payload bytes out and answers every completed frame with one ACK or NAK byte.
module debug_frame_decoder
  import debug_frame_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC0          = SYNC0_DEF,
  parameter logic [7:0]  SYNC1          = SYNC1_DEF,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_reset,
  input  logic       uart_rx_flag,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_tx_done,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  output logic       pl_valid,
  output logic [7:0] pl_data,
  output logic [7:0] pl_index,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic       rx_flag_q;
  logic [7:0] sum_q, sum_d, pay_cnt_q, pay_cnt_d;
  logic [7:0] cmd_q, cmd_d, len_q, len_d;
  logic       pl_valid_q, pl_valid_d;
  logic [7:0] pl_data_q, pl_data_d, pl_index_q, pl_index_d;
  logic       ok_q, ok_d, err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q;

  logic       byte_stb, mid_frame, tmo_expire;
  logic [7:0] csum;

  assign byte_stb  = uart_rx_flag & ~rx_flag_q;
  assign csum      = sum_q + uart_rx_data;
  assign mid_frame = (state_q == S_HUNT1) || (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAY)   || (state_q == S_CHK);

  debug_frame_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (reset_n),
    .srst   (sync_reset),
    .clr    (byte_stb || state_q == S_HUNT0 || state_q == S_TX_START),
    .en     (mid_frame || state_q == S_TX_WAIT),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    pay_cnt_d  = pay_cnt_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    pl_valid_d = 1'b0;
    pl_data_d  = pl_data_q;
    pl_index_d = pl_index_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      S_HUNT0: if (byte_stb && uart_rx_data == SYNC0) state_d = S_HUNT1;
      S_HUNT1: if (byte_stb) begin
        if (uart_rx_data == SYNC1)      state_d = S_CMD;
        else if (uart_rx_data != SYNC0) state_d = S_HUNT0;
      end
      S_CMD: if (byte_stb) begin
        cmd_d   = uart_rx_data;
        sum_d   = uart_rx_data;
        state_d = S_LEN;
      end
      S_LEN: if (byte_stb) begin
        len_d     = uart_rx_data;
        sum_d     = csum;
        pay_cnt_d = '0;
        if (uart_rx_data > MAX_LEN_B) begin
          err_d      = 1'b1;
          err_code_d = ERR_LEN;
          tx_data_d  = NAK_BYTE;
          state_d    = S_TX_START;
        end else if (uart_rx_data == 8'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_PAY;
        end
      end
      S_PAY: if (byte_stb) begin
        pl_valid_d = 1'b1;
        pl_data_d  = uart_rx_data;
        pl_index_d = pay_cnt_q;
        pay_cnt_d  = pay_cnt_q + 8'd1;
        sum_d      = csum;
        if (pay_cnt_q + 8'd1 == len_q) state_d = S_CHK;
      end
      S_CHK: if (byte_stb) begin
        if (csum == 8'd0) begin
          ok_d       = 1'b1;
          err_code_d = ERR_NONE;
          tx_data_d  = ACK_BYTE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_CSUM;
          tx_data_d  = NAK_BYTE;
        end
        state_d = S_TX_START;
      end
      S_TX_START: begin
        tx_start_d = 1'b1;
        state_d    = S_TX_WAIT;
      end
      // A lost tx_done must not wedge the decoder, so expiry here just returns to hunting.
      S_TX_WAIT: if (uart_tx_done || tmo_expire) state_d = S_HUNT0;
      default: state_d = S_HUNT0;
    endcase

    // The watchdog never asserts expire in a cycle with a byte strobe, so a byte always wins.
    if (mid_frame && tmo_expire) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      tx_data_d  = NAK_BYTE;
      state_d    = S_TX_START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || sync_reset) begin
      state_q    <= S_HUNT0;
      rx_flag_q  <= 1'b1;
      sum_q      <= '0;
      pay_cnt_q  <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      pl_valid_q <= 1'b0;
      pl_data_q  <= '0;
      pl_index_q <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_flag_q  <= uart_rx_flag;
      sum_q      <= sum_d;
      pay_cnt_q  <= pay_cnt_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      pl_valid_q <= pl_valid_d;
      pl_data_q  <= pl_data_d;
      pl_index_q <= pl_index_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= (state_d != S_HUNT0);
    end
  end

  assign uart_tx_start = tx_start_q;
  assign uart_tx_data  = tx_data_q;
  assign pl_valid      = pl_valid_q;
  assign pl_data       = pl_data_q;
  assign pl_index      = pl_index_q;
  assign frame_cmd     = cmd_q;
  assign frame_len     = len_q;
  assign frame_ok      = ok_q;
  assign frame_err     = err_q;
  assign err_code      = err_code_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_debug_frame_decoder.sv
// Directed-vector bench for debug_frame_decoder: sends whole frames byte by byte and checks
// payload strobes, status pulses, reply byte, timeout latency and reset behaviour.
module tb_debug_frame_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic       uart_rx_flag = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_tx_done = 1'b0;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       pl_valid;
  logic [7:0] pl_data, pl_index, frame_cmd, frame_len;
  logic       frame_ok, frame_err, busy;
  logic [1:0] err_code;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int last_stb_cyc = 0;
  int err_cyc = 0;
  int n_ok = 0, n_err = 0, n_txs = 0, n_both = 0;
  logic [7:0] tx_byte = 8'h00;
  logic [15:0] pl_seen[$];
  logic [7:0]  exp_pl[$];

  debug_frame_decoder #(.MAX_LEN(16), .TIMEOUT_CYCLES(50)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_reset    (sync_reset),
    .uart_rx_flag  (uart_rx_flag),
    .uart_rx_data  (uart_rx_data),
    .uart_tx_done  (uart_tx_done),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .pl_valid      (pl_valid),
    .pl_data       (pl_data),
    .pl_index      (pl_index),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pl_valid) pl_seen.push_back({pl_index, pl_data});
    if (frame_ok) n_ok++;
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (frame_ok && frame_err) n_both++;
    if (uart_tx_start) begin
      n_txs++;
      tx_byte = uart_tx_data;
    end
  end

  // UART transmitter model: acknowledges each start a few cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_start) begin
        repeat (4) @(negedge clk);
        uart_tx_done = 1'b1;
        @(negedge clk);
        uart_tx_done = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b;
    uart_rx_flag = 1'b1;
    @(posedge clk);
    #1 last_stb_cyc = cyc;
    @(negedge clk);
    @(negedge clk);
    uart_rx_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    n_ok = 0; n_err = 0; n_txs = 0; n_both = 0;
    tx_byte = 8'h00;
    pl_seen.delete();
    exp_pl.delete();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int exp_ok, input int exp_err,
                             input logic [1:0] exp_code, input logic [7:0] exp_tx,
                             input logic [7:0] exp_cmd, input logic [7:0] exp_len);
    check_val({tag, " frame_ok"}, 32'(n_ok), 32'(exp_ok));
    check_val({tag, " frame_err"}, 32'(n_err), 32'(exp_err));
    check_val({tag, " ok&err"}, 32'(n_both), 32'd0);
    check_val({tag, " tx_starts"}, 32'(n_txs), 32'd1);
    check_val({tag, " tx_data"}, 32'(tx_byte), 32'(exp_tx));
    check_val({tag, " err_code"}, 32'(err_code), 32'(exp_code));
    check_val({tag, " frame_cmd"}, 32'(frame_cmd), 32'(exp_cmd));
    check_val({tag, " frame_len"}, 32'(frame_len), 32'(exp_len));
    check_val({tag, " pl_count"}, 32'(pl_seen.size()), 32'(exp_pl.size()));
    for (int i = 0; i < exp_pl.size() && i < pl_seen.size(); i++) begin
      check_val($sformatf("%s pl[%0d]", tag, i), 32'(pl_seen[i]), {16'd0, i[7:0], exp_pl[i]});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst tx_start", 32'(uart_tx_start), 32'd0);
    check_val("rst outputs", {14'd0, pl_valid, frame_ok, frame_err, err_code, pl_index, frame_cmd[4:0]}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame: 10+03+11+22+33 = 79, checksum 87 brings the sum to zero.
    clear_obs();
    exp_pl.push_back(8'h11); exp_pl.push_back(8'h22); exp_pl.push_back(8'h33);
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h87);
    wait_idle("good");
    check_frame("good", 1, 0, 2'd0, 8'h06, 8'h10, 8'h03);

    // Same frame, checksum off by one.
    clear_obs();
    exp_pl.push_back(8'h11); exp_pl.push_back(8'h22); exp_pl.push_back(8'h33);
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h88);
    wait_idle("badsum");
    check_frame("badsum", 0, 1, 2'd1, 8'h15, 8'h10, 8'h03);

    // LEN one above MAX_LEN.
    clear_obs();
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
    wait_idle("badlen");
    check_frame("badlen", 0, 1, 2'd2, 8'h15, 8'h10, 8'h11);

    // Noise and a repeated SYNC0 ahead of a zero-length frame: 20+00+E0 = 100.
    clear_obs();
    send_byte(8'h00); send_byte(8'h5A); send_byte(8'h5A); send_byte(8'hA5);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'hE0);
    wait_idle("zlen");
    check_frame("zlen", 1, 0, 2'd0, 8'h06, 8'h20, 8'h00);

    // Stall after CMD: frame_err lands 50 cycles after the last strobe.
    clear_obs();
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h10);
    wait_idle("tmo");
    check_frame("tmo", 0, 1, 2'd3, 8'h15, 8'h10, 8'h00);
    check_val("tmo latency", 32'(err_cyc - last_stb_cyc), 32'd50);

    // Asynchronous reset mid-payload.
    clear_obs();
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    check_val("pre-rst pl_index", 32'(pl_index), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst busy", 32'(busy), 32'd0);
    check_val("arst cmd/len", {16'd0, frame_cmd, frame_len}, 32'd0);
    check_val("arst tx_data/err", {22'd0, uart_tx_data, err_code}, 32'd0);
    check_val("arst pl_index", 32'(pl_index), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    clear_obs();
    exp_pl.push_back(8'h11); exp_pl.push_back(8'h22); exp_pl.push_back(8'h33);
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h87);
    wait_idle("post-rst");
    check_frame("post-rst", 1, 0, 2'd0, 8'h06, 8'h10, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
